regfile_sb: RTL
===============

// Module: regfile_sb
// PURPOSE
//   Parametrised register file: 2 write ports, 2 read ports, same-cycle write->read bypass,
//   per-register scoreboard (pending bits) for multi-cycle/pipelined datapaths.
//   Index PC_IDX reads the externally supplied PC value (r15 = PC+8); it is never stored.
//   Sits between decode (reads, issue) and writeback (ports 3/4) of the pipelined core.
// PARAMETERS
//   DW      32  data width of every register
//   NREG    16  architectural register count, including the PC slot
//   AW      4   address width; must satisfy 2**AW >= NREG
//   PC_IDX  15  index aliased to r15 input; must be < NREG
//   BYPASS  1   1: reads/busy see same-cycle writebacks; 0: see registered state only
// PORTS
//   clk         in   1        clock, all state on rising edge
//   reset       in   1        synchronous, active-high
//   ra1, ra2    in   AW       read addresses
//   rd1, rd2    out  DW       read data (combinational)
//   busy1,busy2 out  1        pending bit of ra1/ra2 (combinational)
//   r15         in   DW       PC+8 value returned for reads of PC_IDX
//   we3         in   1        write enable, port 3 (ALU/load result)
//   a3          in   AW       write address, port 3
//   wd3         in   DW       write data, port 3
//   we4         in   1        write enable, port 4 (base writeback / long-multiply high word)
//   a4          in   AW       write address, port 4
//   wd4         in   DW       write data, port 4
//   issue       in   1        instruction issued with destination issue_dst
//   issue_dst   in   AW       destination marked pending at issue
//   pend_cnt    out  AW+1     number of pending registers (registered)
// BEHAVIOUR
//   Reset: reset=1 at a clock edge clears every rf entry to 0, all pending bits, and
//     pend_cnt; it overrides writes and issues in that cycle. While reset=1: rd*=0 (PC_IDX
//     reads still return r15), busy*=0, bypass disabled.
//   Write: rf[aN] <= wdN on the edge when weN=1. Same address on both ports: port 4 wins.
//     Writes to PC_IDX or to any address >= NREG are dropped.
//   Read: raN==PC_IDX -> r15; raN>=NREG -> 0; else rf[raN]. With BYPASS=1 and a matching
//     enabled write in the same cycle -> that wd (port 4 over port 3). Zero-latency.
//   Scoreboard: pending[r] is set at the edge when issue=1 and issue_dst=r. It is cleared at the
//     edge when any write port writes r. Set and clear on the same r in one cycle: set wins
//     (a new producer has issued). issue to PC_IDX or >= NREG is ignored.
//   busyN = pending[raN], masked to 0 when BYPASS=1 and a same-cycle write clears raN.
//     busyN is always 0 for raN == PC_IDX. Same-cycle issue does not affect busy.
//   pend_cnt: registered popcount of pending after the edge; range 0..NREG-1, never wraps.
//   No stall logic inside: decode stalls when busy1|busy2. Issuing to an already-pending
//     register keeps it pending (no counting of multiple producers).
// TESTING
//   reset 1 cycle, then read all addrs with r15=0x108 -> rd=0 for r0..r14, rd=0x108 for ra=15.
//   we3=1,a3=2,wd3=0xDEAD_BEEF with ra1=2 -> same-cycle rd1=0xDEADBEEF (BYPASS=1); next cycle
//     still 0xDEADBEEF; with BYPASS=0 same-cycle rd1=0.
//   we3,we4 both to r5, wd3=0x11, wd4=0x22 -> rf[5]=0x22; we3 to r15 -> readback still r15.
//   issue r7 -> busy1(ra1=7)=1, pend_cnt=1; later we4 a4=7 -> busy1=0 same cycle, pend_cnt=0.
//   issue r3 and we3 a3=3 in the same cycle -> r3 pending afterwards, rf[3]=wd3, pend_cnt=1.
//   issue r1,r2,r4, then reset mid-sequence with we3 active -> all pending 0, pend_cnt=0, rf=0.

Source files
------------

// File: rtl/regfile_sb.sv
// Register file with two write ports, two read ports, an optional same-cycle write->read
// bypass, and a per-register pending scoreboard for the decode/writeback handshake.
module regfile_sb #(
  parameter int DW     = 32,
  parameter int NREG   = 16,
  parameter int AW     = 4,
  parameter int PC_IDX = 15,
  parameter int BYPASS = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  output logic          busy1,
  output logic          busy2,
  input  logic [DW-1:0] r15,
  input  logic          we3,
  input  logic [AW-1:0] a3,
  input  logic [DW-1:0] wd3,
  input  logic          we4,
  input  logic [AW-1:0] a4,
  input  logic [DW-1:0] wd4,
  input  logic          issue,
  input  logic [AW-1:0] issue_dst,
  output logic [AW:0]   pend_cnt
);

  // Storage spans the full address space so any read address indexes it directly;
  // slots that are not real registers (PC and >= NREG) are never written and stay 0.
  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] PC_A = AW'(PC_IDX);

  logic [DW-1:0]    rf_reg  [DEPTH];
  logic [DW-1:0]    rf_next [DEPTH];
  logic [DEPTH-1:0] pending_reg;
  logic [DEPTH-1:0] pending_next;
  logic [AW:0]      pend_cnt_reg;
  logic [AW:0]      pend_cnt_next;

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] wr3_hit;
  logic [DEPTH-1:0] wr4_hit;
  logic [DEPTH-1:0] iss_hit;

  genvar gi;

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_dec
      localparam logic [AW-1:0] IDX = AW'(gi);
      assign valid[gi]   = (gi < NREG) && (gi != PC_IDX);
      assign wr3_hit[gi] = valid[gi] & we3 & (a3 == IDX);
      assign wr4_hit[gi] = valid[gi] & we4 & (a4 == IDX);
      assign iss_hit[gi] = valid[gi] & issue & (issue_dst == IDX);
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rf_next[i] = rf_reg[i];
      if (wr4_hit[i]) begin
        rf_next[i] = wd4;
      end else if (wr3_hit[i]) begin
        rf_next[i] = wd3;
      end
    end
    // A new issue outranks a writeback from the previous producer of the same register.
    pending_next  = (pending_reg & ~(wr3_hit | wr4_hit)) | iss_hit;
    pend_cnt_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pend_cnt_next = pend_cnt_next + {{AW{1'b0}}, pending_next[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        rf_reg[i] <= '0;
      end
      pending_reg  <= '0;
      pend_cnt_reg <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        rf_reg[i] <= rf_next[i];
      end
      pending_reg  <= pending_next;
      pend_cnt_reg <= pend_cnt_next;
    end
  end

  assign pend_cnt = pend_cnt_reg;

  // Read ports: identical logic, one instance per port.
  logic [1:0][AW-1:0] ra_v;
  assign ra_v = {ra2, ra1};

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [DW-1:0] rd_p;
      logic          busy_p;

      always_comb begin
        rd_p   = rf_reg[ra_v[gi]];
        busy_p = pending_reg[ra_v[gi]];
        if (BYPASS != 0) begin
          if (wr4_hit[ra_v[gi]]) begin
            rd_p   = wd4;
            busy_p = 1'b0;
          end else if (wr3_hit[ra_v[gi]]) begin
            rd_p   = wd3;
            busy_p = 1'b0;
          end
        end
        if (reset || !valid[ra_v[gi]]) begin
          rd_p   = '0;
          busy_p = 1'b0;
        end
        if (ra_v[gi] == PC_A) begin
          rd_p = r15;
        end
      end
    end
  endgenerate

  assign rd1   = g_rd[0].rd_p;
  assign rd2   = g_rd[1].rd_p;
  assign busy1 = g_rd[0].busy_p;
  assign busy2 = g_rd[1].busy_p;

endmodule
